// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one combinational WIDTHxWIDTH multiplier among N_REQ requesters, 2-cycle latency.
// Optional build macro MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_ain,
  input  logic [N_REQ*WIDTH-1:0]   req_bin,
  output logic [WIDTH-1:0]         mul_ain,
  output logic [WIDTH-1:0]         mul_bin,
  input  logic [2*WIDTH-1:0]       mul_dout,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_dout,
  output logic                     busy
);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    idx;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] s1_id;
  logic             s1_valid;
  logic             xfer;

  // First valid requester searching upward from ptr with wrap-around.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    xfer  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!xfer && req_valid[idx]) begin
        xfer        = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  assign req_ready = grant;

`ifdef MUL_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (xfer)
      ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
  end
`endif

  // Stage 1: operands feed the multiplier directly from these registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      mul_ain  <= '0;
      mul_bin  <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_id   <= grant;
        mul_ain <= req_ain[gidx*WIDTH +: WIDTH];
        mul_bin <= req_bin[gidx*WIDTH +: WIDTH];
      end
    end
  end

  // Stage 2: capture product; rsp_dout holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_dout  <= '0;
    end else if (s1_valid) begin
      rsp_valid <= s1_id;
      rsp_dout  <= mul_dout;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign busy = s1_valid | (|rsp_valid);
endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized traffic against a scoreboard model.
module tb_mul_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_ain, req_bin;
  logic [W-1:0]   mul_ain, mul_bin;
  logic [2*W-1:0] mul_dout, rsp_dout;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  mul_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ain(req_ain), .req_bin(req_bin),
    .mul_ain(mul_ain), .mul_bin(mul_bin), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .busy(busy)
  );

  // The shared multiplier itself.
  assign mul_dout = {{W{1'b0}}, mul_ain} * {{W{1'b0}}, mul_bin};

  always #5 clk = ~clk;

  // Scoreboard: acceptances keyed by the edge number at which they occurred.
  int             m_ptr;
  int             edge_n = 0;
  int             acc_id [int];
  logic [2*W-1:0] acc_p  [int];
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_dout;

  function automatic void model_reset();
    m_ptr = 0;
    acc_id.delete();
    acc_p.delete();
    m_a = '0; m_b = '0; m_dout = '0;
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one;
    one = 1;
    return (i >= 0) ? (one << i) : '0;
  endfunction

  // One clock: check grant, advance the model across the edge, check outputs after it.
  task automatic tick();
    int g;
    logic [N-1:0] exp_rv;
    logic exp_busy;
    #1;
    g = pick(req_valid);
    n_cmp++;
    if (req_ready !== onehot(g)) begin
      n_bad++; $display("FAIL grant edge=%0d got=%b exp=%b", edge_n, req_ready, onehot(g));
    end
    @(posedge clk);
    edge_n++;
    if (g >= 0) begin
      m_a = req_ain[g*W +: W];
      m_b = req_bin[g*W +: W];
      acc_id[edge_n] = g;
      acc_p[edge_n]  = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
`ifndef MUL_ARB_FIXED_PRIO_EN
      m_ptr = (g + 1) % N;
`endif
    end
    #1;
    exp_rv = '0;
    if (acc_id.exists(edge_n - 1)) begin
      exp_rv = onehot(acc_id[edge_n - 1]);
      m_dout = acc_p[edge_n - 1];
    end
    exp_busy = acc_id.exists(edge_n) || acc_id.exists(edge_n - 1);
    n_cmp++;
    if (rsp_valid !== exp_rv) begin
      n_bad++; $display("FAIL rsp_valid edge=%0d got=%b exp=%b", edge_n, rsp_valid, exp_rv);
    end
    n_cmp++;
    if (rsp_dout !== m_dout) begin
      n_bad++; $display("FAIL rsp_dout edge=%0d got=%h exp=%h", edge_n, rsp_dout, m_dout);
    end
    n_cmp++;
    if (busy !== exp_busy) begin
      n_bad++; $display("FAIL busy edge=%0d got=%b exp=%b", edge_n, busy, exp_busy);
    end
    n_cmp++;
    if (mul_ain !== m_a || mul_bin !== m_b) begin
      n_bad++; $display("FAIL mul_operands edge=%0d got=%h/%h exp=%h/%h", edge_n, mul_ain, mul_bin, m_a, m_b);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_ain[i*W +: W] = a;
    req_bin[i*W +: W] = b;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (rsp_valid !== '0 || rsp_dout !== '0 || mul_ain !== '0 || mul_bin !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_state got rv=%b d=%h a=%h b=%h busy=%b exp all 0", rsp_valid, rsp_dout, mul_ain, mul_bin, busy);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_contention();
    logic [2*W-1:0] vals [4];
    vals[0] = 10; vals[1] = 40; vals[2] = 90; vals[3] = 160;
    for (int i = 0; i < N; i++) set_req(i, 10 * (i + 1), i + 1);
    req_valid = '1;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) begin
        n_cmp++;
        if (req_ready !== onehot(c % 4)) begin
          n_bad++; $display("FAIL contention_grant c=%0d got=%b exp=%b", c, req_ready, onehot(c % 4));
        end
      end
      tick();
      if (c >= 1) begin
        n_cmp++;
        if (rsp_valid !== onehot((c - 1) % 4) || rsp_dout !== vals[(c - 1) % 4]) begin
          n_bad++; $display("FAIL contention_rsp c=%0d got=%b/%0d exp=%b/%0d", c, rsp_valid, rsp_dout, onehot((c - 1) % 4), vals[(c - 1) % 4]);
        end
      end
    end
    tick();
  endtask

  task automatic test_single();
    set_req(0, 10, 1);
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_dout !== 64'd10) begin
      n_bad++; $display("FAIL single_rsp got=%b/%0d exp=0001/10", rsp_valid, rsp_dout);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_end got rv=%b busy=%b exp 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_wrap_skip();
    for (int i = 0; i < N; i++) set_req(i, i + 3, 7);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0011;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL wrap_grant0 got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL wrap_grant1 got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_dout !== 64'd21) begin
      n_bad++; $display("FAIL wrap_rsp0 got=%b/%0d exp=0001/21", rsp_valid, rsp_dout);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 4'b0010 || rsp_dout !== 64'd28) begin
      n_bad++; $display("FAIL wrap_rsp1 got=%b/%0d exp=0010/28", rsp_valid, rsp_dout);
    end
    tick();
  endtask

  task automatic test_width();
    set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    n_cmp++;
    if (rsp_valid !== 4'b1000 || rsp_dout !== 64'hFFFF_FFFE_0000_0001) begin
      n_bad++; $display("FAIL width_rsp got=%b/%h exp=1000/fffffffe00000001", rsp_valid, rsp_dout);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      tick();
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    set_req(2, 5, 6);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== '0 || rsp_dout !== '0 || mul_ain !== '0 || mul_bin !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midflight_async got rv=%b d=%h a=%h b=%h busy=%b exp all 0", rsp_valid, rsp_dout, mul_ain, mul_bin, busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL midflight_hold c=%0d got rv=%b busy=%b exp 0/0", c, rsp_valid, busy);
      end
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, i + 1, 2);
    req_valid = '1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL midflight_restart got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

`ifdef MUL_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0001) begin
        n_bad++; $display("FAIL fixed_all c=%0d got=%b exp=0001", c, req_ready);
      end
      tick();
    end
    req_valid = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0010) begin
        n_bad++; $display("FAIL fixed_drop0 c=%0d got=%b exp=0010", c, req_ready);
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_ain   = '0;
    req_bin   = '0;
    model_reset();
    test_reset();
`ifndef MUL_ARB_FIXED_PRIO_EN
    test_contention();
`endif
    test_single();
    test_wrap_skip();
    test_width();
    test_random();
    test_reset_midflight();
`ifdef MUL_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
